// File: rtl/ram8_16bit_pkg.sv
// rtl/ram8_16bit_pkg.sv - shared constants and state type for the RAM8 storage stage
package ram8_16bit_pkg;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/ram8_16bit_mux8to1.sv
// rtl/ram8_16bit_mux8to1.sv - 8-to-1 16-bit read mux
module mux8to1_16bit
  import ram8_16bit_pkg::*;
(
  input  logic [WIDTH-1:0]  in0_i,
  input  logic [WIDTH-1:0]  in1_i,
  input  logic [WIDTH-1:0]  in2_i,
  input  logic [WIDTH-1:0]  in3_i,
  input  logic [WIDTH-1:0]  in4_i,
  input  logic [WIDTH-1:0]  in5_i,
  input  logic [WIDTH-1:0]  in6_i,
  input  logic [WIDTH-1:0]  in7_i,
  input  logic [ADDR_W-1:0] sel_i,
  output logic [WIDTH-1:0]  out_o
);

  always_comb begin
    out_o = in0_i;
    case (sel_i)
      3'd0: out_o = in0_i;
      3'd1: out_o = in1_i;
      3'd2: out_o = in2_i;
      3'd3: out_o = in3_i;
      3'd4: out_o = in4_i;
      3'd5: out_o = in5_i;
      3'd6: out_o = in6_i;
      3'd7: out_o = in7_i;
      default: out_o = in0_i;
    endcase
  end

endmodule

// File: rtl/ram8_16bit.sv
// rtl/ram8_16bit.sv - eight-word 16-bit register bank with built-in clear sweep
module ram8_16bit
  import ram8_16bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [WIDTH-1:0]   wr_data;

  // A single write port is shared between host loads and the sweep's zeroing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    wr_en   = 1'b0;
    wr_addr = address;
    wr_data = in;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else if (load) begin
          wr_en = 1'b1;
        end
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'(DEPTH - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      if (wr_en) mem_q[wr_addr] <= wr_data;
    end
  end

  assign busy = busy_q;

  mux8to1_16bit u_mux (
    .in0_i (mem_q[0]),
    .in1_i (mem_q[1]),
    .in2_i (mem_q[2]),
    .in3_i (mem_q[3]),
    .in4_i (mem_q[4]),
    .in5_i (mem_q[5]),
    .in6_i (mem_q[6]),
    .in7_i (mem_q[7]),
    .sel_i (address),
    .out_o (out)
  );

endmodule

// File: tb/tb_ram8_16bit.sv
// tb/tb_ram8_16bit.sv - directed self-checking bench for ram8_16bit
`timescale 1ns/100ps
module tb_ram8_16bit;

  logic        clk;
  logic        rst;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic        clear;
  logic [15:0] out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] mdl [8];
  logic [15:0] sb_q [$];
  logic [15:0] vals [8];

  ram8_16bit dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .load    (load),
    .address (address),
    .clear   (clear),
    .out     (out),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [2:0] a, input logic [15:0] d);
    address = a;
    in      = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
    mdl[a]  = d;
  endtask

  // Expected word pushed from the model, popped when the DUT output is read.
  task automatic check_word(input string tag, input logic [2:0] a);
    address = a;
    sb_q.push_back(mdl[a]);
    #1;
    chk(tag, out, sb_q.pop_front());
  endtask

  initial begin
    int cyc;
    vals[0] = 16'hFFFF; vals[1] = 16'h0000; vals[2] = 16'hFE00; vals[3] = 16'h01FF;
    vals[4] = 16'h11FF; vals[5] = 16'h01F7; vals[6] = 16'h41F7; vals[7] = 16'hC1FF;
    rst = 1'b0; in = '0; load = 1'b0; address = '0; clear = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;

    #1 rst = 1'b1;
    #1;
    chk("reset_busy", {15'b0, busy}, 16'h0000);
    for (int i = 0; i < 8; i++) check_word("reset_word", 3'(i));
    #1 rst = 1'b0;
    tick();

    // Write/readback: expectations queued at write time
    for (int i = 0; i < 8; i++) begin
      write(3'(i), vals[i]);
      sb_q.push_back(vals[i]);
    end
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1;
      chk("readback", out, sb_q.pop_front());
    end

    // Same-cycle write then read at address 3
    address = 3'd3; in = 16'hABCD; load = 1'b1;
    #1;
    chk("same_cycle_old", out, 16'h01FF);
    tick();
    load = 1'b0;
    mdl[3] = 16'hABCD;
    chk("same_cycle_new", out, 16'hABCD);
    check_word("neighbour_lo", 3'd2);
    check_word("neighbour_hi", 3'd4);

    // Clear sweep with a blocked load at edge t+4
    for (int i = 0; i < 8; i++) write(3'(i), 16'hFFFF);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("sweep_busy_t", {15'b0, busy}, 16'h0001);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        address = 3'd5; in = 16'h1234; load = 1'b1;
        tick();
        load = 1'b0;
      end else begin
        address = 3'(k);
        #1;
        chk("sweep_before", out, 16'hFFFF);
        tick();
        chk("sweep_after", out, 16'h0000);
      end
      chk("sweep_busy", {15'b0, busy}, (k == 7) ? 16'h0000 : 16'h0001);
    end
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    write(3'd6, 16'h7777);
    for (int i = 0; i < 8; i++) check_word("post_sweep", 3'(i));

    // Clear and load together in IDLE: clear wins
    write(3'd2, 16'h0F0F);
    address = 3'd2; in = 16'h5555; load = 1'b1; clear = 1'b1;
    tick();
    load = 1'b0; clear = 1'b0;
    chk("clr_load_busy", {15'b0, busy}, 16'h0001);
    cyc = 1;
    while (busy === 1'b1 && cyc < 20) begin
      tick();
      if (busy === 1'b1) cyc++;
    end
    chk("clr_load_len", 16'(cyc), 16'd8);
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    check_word("clr_load_w2", 3'd2);
    check_word("clr_load_w6", 3'd6);

    // Reset mid-sweep
    write(3'd1, 16'hAAAA);
    write(3'd7, 16'hBBBB);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick(); tick(); tick();
    address = 3'd7;
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", {15'b0, busy}, 16'h0000);
    chk("midrst_w7", out, 16'h0000);
    address = 3'd1;
    #1;
    chk("midrst_w1", out, 16'h0000);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    write(3'd4, 16'h4444);
    check_word("post_rst_load", 3'd4);
    chk("post_rst_busy", {15'b0, busy}, 16'h0000);
    check_word("post_rst_w7", 3'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
